data_request: RTL and testbench
===============================

# data_request

Transmit-side GMII reconciliation block: turns a byte-stream frame request from the MAC into GMII transmit signalling (txd, tx_en, tx_er) on the transmit clock. It inserts preamble and SFD, streams payload bytes, propagates data errors, and generates carrier extension and carrier-extend-error symbols. It then enforces the inter-packet gap. It is the transmit counterpart of the receive-side data indication logic in the reconciliation layer.

## Interface
- PREAMBLE_LEN, 7, number of 0x55 preamble bytes before SFD (1..15)
- IPG_LEN, 12, idle cycles enforced after each frame (1..255)

- tx_clk  in  1  transmit clock; all state changes on rising edge
- tx_rst_n  in  1  asynchronous, active-low reset
- data_in  in  8  payload byte
- data_valid  in  1  data_in valid; in IDLE also requests frame start
- data_last  in  1  qualifies the accepted byte as final byte of frame
- data_error  in  1  accepted byte is to be sent with tx_er=1
- ext_len  in  8  carrier-extension cycle count, sampled with last byte; 0 = none
- ext_err  in  1  when high during EXTEND, symbol becomes 0x1F instead of 0x0F
- data_ready  out  1  byte accepted on edge where data_valid & data_ready
- busy  out  1  high whenever state is not IDLE
- txd  out  8  GMII transmit data, registered
- tx_en  out  1  GMII transmit enable, registered
- tx_er  out  1  GMII transmit error, registered

## Operation
- States: IDLE, PREAMBLE, SFD, DATA, EXTEND, IPG. 4-bit preamble counter, 8-bit extend/IPG counter.
- IDLE: txd=0x00, tx_en=0, tx_er=0. data_valid=1 -> PREAMBLE.
- PREAMBLE: PREAMBLE_LEN cycles of txd=0x55, tx_en=1, tx_er=0 -> SFD.
- SFD: one cycle txd=0xD5, tx_en=1 -> DATA.
- data_ready = combinational, high in SFD and DATA states only; low elsewhere.
- DATA, accepted byte: txd=data_in, tx_en=1, tx_er=data_error. If data_last=1: go to EXTEND when ext_len!=0 (load counter with ext_len), else IPG.
- DATA underrun (data_valid=0 while data_ready=1): one cycle txd=0x00, tx_en=1, tx_er=1 (data reception error seen by peer), frame aborted -> IPG. No extension after an abort.
- EXTEND: ext_len cycles of tx_en=0, tx_er=1, txd=0x0F; txd=0x1F on any cycle where ext_err=1. Then -> IPG.
- IPG: IPG_LEN cycles of txd=0x00, tx_en=0, tx_er=0, then -> IDLE. data_valid ignored; data_ready=0.
- busy = (state != IDLE).

## Timing
- Reset (tx_rst_n=0, asynchronous): state IDLE, counters 0, txd=0x00, tx_en=0, tx_er=0, busy=0, data_ready=0. Takes effect immediately, including mid-frame; no IPG after reset release.
- Edge E0 = edge where IDLE samples data_valid=1. Preamble appears after E1..E(PREAMBLE_LEN). SFD appears after E(PREAMBLE_LEN+1). data_ready is high in the cycle before E(PREAMBLE_LEN+2).
- Byte accepted on edge Ek appears on txd after Ek; latency one edge. Source holds data_in/data_valid stable until accepted.
- Default params: the first byte is accepted at E9 and is on txd after E9. A frame of N bytes without extension returns to IDLE after E(8+N+IPG_LEN).
- data_last with ext_len=L: extension occupies the L edges after the last byte, then IPG_LEN idle edges.
- Back-to-back request: data_valid held high during IPG starts a new frame on the first IDLE edge. The minimum gap between tx_en=0 and tx_en=1 is IPG_LEN+1 cycles.

## Configuration
- CARRIER_EXT_EN defined: EXTEND state and ext_len/ext_err behaviour as above.
- Undefined: EXTEND state not compiled in. ext_len and ext_err are ignored. data_last always goes to IPG, and tx_er is only ever driven by data_error or underrun.

## Test plan
- Reset mid-frame: assert tx_rst_n=0 during DATA -> txd=0x00, tx_en=0, tx_er=0, busy=0 immediately. After release, IDLE is held until data_valid.
- 3-byte frame 0xAA,0xBB,0xCC, ext_len=0 -> sequence 7×0x55, 0xD5, AA, BB, CC with tx_en=1, then 12 cycles tx_en=0, then busy=0.
- Byte 2 sent with data_error=1 -> that cycle tx_en=1, tx_er=1, txd=0xBB; other bytes tx_er=0.
- Underrun after the first byte -> one cycle tx_en=1, tx_er=1, txd=0x00, then IPG_LEN idle cycles. No 0x0F is emitted.
- CARRIER_EXT_EN, ext_len=4, ext_err=1 on the third extend cycle -> txd 0x0F, 0x0F, 0x1F, 0x0F with tx_en=0, tx_er=1, then IPG.
- data_valid held high continuously for two frames -> second preamble starts exactly IPG_LEN+1 cycles after the last tx_en=1 of the first frame.

Source files
------------

// File: rtl/data_request.sv
// GMII transmit reconciliation: preamble/SFD, payload with tx_er, optional carrier extension (CARRIER_EXT_EN), IPG.
// Latency: a byte accepted on an edge is on txd after that same edge; txd/tx_en/tx_er are registered.
// Backpressure: data_ready only in SFD/DATA; a missing byte there aborts the frame with an error symbol.
module data_request #(
  parameter int unsigned PREAMBLE_LEN = 7,
  parameter int unsigned IPG_LEN      = 12
) (
  input  logic       tx_clk,
  input  logic       tx_rst_n,
  input  logic [7:0] data_in,
  input  logic       data_valid,
  input  logic       data_last,
  input  logic       data_error,
  input  logic [7:0] ext_len,
  input  logic       ext_err,
  output logic       data_ready,
  output logic       busy,
  output logic [7:0] txd,
  output logic       tx_en,
  output logic       tx_er
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PREAMBLE,
    S_SFD,
    S_DATA,
    S_IPG
`ifdef CARRIER_EXT_EN
    , S_EXTEND
`endif
  } state_t;

  localparam logic [3:0] PRE_LAST = 4'(PREAMBLE_LEN);
  localparam logic [7:0] IPG_LAST = 8'(IPG_LEN - 1);

  state_t     state_q, state_d;
  logic [3:0] pre_cnt_q, pre_cnt_d;
  logic [7:0] cnt_q, cnt_d;
  logic [7:0] txd_q, txd_d;
  logic       tx_en_q, tx_en_d;
  logic       tx_er_q, tx_er_d;

`ifndef CARRIER_EXT_EN
  logic unused_ext;
  assign unused_ext = ^{ext_len, ext_err};
`endif

  assign data_ready = (state_q == S_SFD) || (state_q == S_DATA);
  assign busy       = (state_q != S_IDLE);
  assign txd        = txd_q;
  assign tx_en      = tx_en_q;
  assign tx_er      = tx_er_q;

  always_comb begin
    state_d   = state_q;
    pre_cnt_d = pre_cnt_q;
    cnt_d     = cnt_q;
    txd_d     = 8'h00;
    tx_en_d   = 1'b0;
    tx_er_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (data_valid) begin
          state_d   = S_PREAMBLE;
          pre_cnt_d = 4'd0;
        end
      end
      // The outputs trail the state by one edge, so the SFD byte is
      // launched on the edge that leaves PREAMBLE.
      S_PREAMBLE: begin
        tx_en_d = 1'b1;
        if (pre_cnt_q == PRE_LAST) begin
          txd_d   = 8'hD5;
          state_d = S_SFD;
        end else begin
          txd_d     = 8'h55;
          pre_cnt_d = pre_cnt_q + 4'd1;
        end
      end
      S_SFD, S_DATA: begin
        tx_en_d = 1'b1;
        if (data_valid) begin
          txd_d   = data_in;
          tx_er_d = data_error;
          state_d = S_DATA;
          if (data_last) begin
            cnt_d   = 8'd0;
            state_d = S_IPG;
`ifdef CARRIER_EXT_EN
            if (ext_len != 8'd0) begin
              cnt_d   = ext_len;
              state_d = S_EXTEND;
            end
`endif
          end
        end else begin
          // Underrun: the peer sees a reception error and the frame ends here.
          tx_er_d = 1'b1;
          cnt_d   = 8'd0;
          state_d = S_IPG;
        end
      end
`ifdef CARRIER_EXT_EN
      S_EXTEND: begin
        tx_er_d = 1'b1;
        txd_d   = ext_err ? 8'h1F : 8'h0F;
        if (cnt_q == 8'd1) begin
          cnt_d   = 8'd0;
          state_d = S_IPG;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
`endif
      S_IPG: begin
        if (cnt_q == IPG_LAST) begin
          cnt_d   = 8'd0;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge tx_clk or negedge tx_rst_n) begin
    if (!tx_rst_n) begin
      state_q   <= S_IDLE;
      pre_cnt_q <= 4'd0;
      cnt_q     <= 8'd0;
      txd_q     <= 8'h00;
      tx_en_q   <= 1'b0;
      tx_er_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      pre_cnt_q <= pre_cnt_d;
      cnt_q     <= cnt_d;
      txd_q     <= txd_d;
      tx_en_q   <= tx_en_d;
      tx_er_q   <= tx_er_d;
    end
  end

endmodule

// File: tb/tb_data_request.sv
// Bench for data_request: table-driven frames, hand sequences (reset, back-to-back) and random frames.
module tb_data_request;

  localparam int P   = 7;
  localparam int IPG = 12;
`ifdef CARRIER_EXT_EN
  localparam bit EXT = 1'b1;
`else
  localparam bit EXT = 1'b0;
`endif

  logic       tx_clk;
  logic       tx_rst_n;
  logic [7:0] data_in;
  logic       data_valid;
  logic       data_last;
  logic       data_error;
  logic [7:0] ext_len;
  logic       ext_err;
  logic       data_ready;
  logic       busy;
  logic [7:0] txd;
  logic       tx_en;
  logic       tx_er;

  data_request #(.PREAMBLE_LEN(P), .IPG_LEN(IPG)) dut (
    .tx_clk     (tx_clk),
    .tx_rst_n   (tx_rst_n),
    .data_in    (data_in),
    .data_valid (data_valid),
    .data_last  (data_last),
    .data_error (data_error),
    .ext_len    (ext_len),
    .ext_err    (ext_err),
    .data_ready (data_ready),
    .busy       (busy),
    .txd        (txd),
    .tx_en      (tx_en),
    .tx_er      (tx_er)
  );

  initial tx_clk = 1'b0;
  always #5 tx_clk = ~tx_clk;

  typedef struct packed {
    int          n;
    int          und;
    int          ext;
    int          eerr;
    int          exp_busy;
    logic [31:0] dat;
    logic [3:0]  err;
  } vec_t;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int fall_cyc = 0;
  int last_gap = -1;
  logic prev_en = 1'b0;

  logic [7:0] fr_dat [0:15];
  logic       fr_err [0:15];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Observation vector: {txd, tx_en, tx_er, busy, data_ready}
  task automatic tick(output logic [11:0] v);
    @(posedge tx_clk);
    #1;
    v = {txd, tx_en, tx_er, busy, data_ready};
    if (tx_en && !prev_en) last_gap = cyc - fall_cyc;
    if (!tx_en && prev_en) fall_cyc = cyc;
    prev_en = tx_en;
    cyc++;
  endtask

  task automatic idle_cycles(input string name, input int cnt);
    logic [11:0] v;
    for (int k = 0; k < cnt; k++) begin
      data_valid = 1'b0;
      data_in    = 8'($urandom);
      tick(v);
      check($sformatf("%s idle%0d", name, k), 32'(v), 32'h0);
    end
  endtask

  // Expected frame on the wire, edge k after the request edge E0:
  // 0: idle | 1..P: 0x55 | P+1: 0xD5 | bytes | abort symbol | extension | IPG zeros.
  task automatic run_frame(input int fid, input int n, input int und, input int ext,
                           input int eerr, input bit b2b, input int stop_at, output int busy_cnt);
    int base, nb, ab, ext_cyc, ipg_start, total, i, j;
    logic [11:0] exp_v, act_v;
    base      = P + 2;
    ab        = (und < n) ? 1 : 0;
    nb        = (ab != 0) ? und : n;
    ext_cyc   = (EXT && ab == 0) ? ext : 0;
    ipg_start = base + nb + ab + ext_cyc;
    total     = ipg_start + IPG;
    busy_cnt  = 0;
    for (int k = 0; k < total; k++) begin
      data_valid = 1'b1;
      data_in    = fr_dat[0];
      data_last  = 1'b0;
      data_error = 1'b0;
      ext_len    = 8'($urandom_range(1, 255));
      ext_err    = 1'($urandom);
      i          = k - base;
      j          = k - (base + n);
      if (k >= base && i < nb) begin
        data_in    = fr_dat[i];
        data_error = fr_err[i];
        data_last  = (i == n - 1);
        if (i == n - 1) ext_len = 8'(ext);
      end else if (k >= base) begin
        data_valid = (ab != 0 && k == base + nb) ? 1'b0 : b2b;
        data_in    = 8'($urandom);
        data_error = 1'($urandom);
        data_last  = 1'($urandom);
      end
      if (ab == 0 && j >= 0 && j < ext)
        ext_err = (eerr < 0) ? 1'($urandom) : (j + 1 == eerr);

      if (k == 0)                 exp_v = {8'h00, 1'b0, 1'b0, 1'b1, 1'b0};
      else if (k <= P)            exp_v = {8'h55, 1'b1, 1'b0, 1'b1, 1'b0};
      else if (k == P + 1)        exp_v = {8'hD5, 1'b1, 1'b0, 1'b1, 1'b1};
      else if (i < nb)            exp_v = {fr_dat[i], 1'b1, fr_err[i], 1'b1, (i != n - 1)};
      else if (i < nb + ab)       exp_v = {8'h00, 1'b1, 1'b1, 1'b1, 1'b0};
      else if (k < ipg_start)     exp_v = {(ext_err ? 8'h1F : 8'h0F), 1'b0, 1'b1, 1'b1, 1'b0};
      else                        exp_v = {8'h00, 1'b0, 1'b0, (k != total - 1), 1'b0};

      tick(act_v);
      check($sformatf("frm%0d cyc%0d", fid, k), 32'(act_v), 32'(exp_v));
      if (act_v[1]) busy_cnt++;
      if (k == stop_at) break;
    end
  endtask

  initial begin
    vec_t vecs [0:6];
    logic [11:0] v;
    int bc, n, und, ext;

    tx_rst_n   = 1'b0;
    data_in    = 8'h00;
    data_valid = 1'b0;
    data_last  = 1'b0;
    data_error = 1'b0;
    ext_len    = 8'h00;
    ext_err    = 1'b0;

    // n, und (>=n: none), ext_len, ext_err cycle, busy cycles, bytes (LSB first), byte errors
    vecs[0] = '{3, 3, 0, 0, 23,              32'h00CCBBAA, 4'b0000};
    vecs[1] = '{3, 3, 0, 0, 23,              32'h00CCBBAA, 4'b0010};
    vecs[2] = '{3, 1, 0, 0, 22,              32'h00CCBBAA, 4'b0000};
    vecs[3] = '{3, 3, 4, 3, (EXT ? 27 : 23), 32'h00CCBBAA, 4'b0000};
    vecs[4] = '{1, 1, 0, 0, 21,              32'h0000005A, 4'b0000};
    vecs[5] = '{2, 0, 3, 0, 21,              32'h00001234, 4'b0000};
    vecs[6] = '{4, 4, 1, 1, (EXT ? 25 : 24), 32'hF00D8001, 4'b1001};

    #12;
    check("reset outputs", 32'({txd, tx_en, tx_er, busy, data_ready}), 32'h0);
    tick(v);
    check("reset held over edge", 32'(v), 32'h0);
    tx_rst_n = 1'b1;
    idle_cycles("post-reset", 3);

    for (int t = 0; t < 7; t++) begin
      for (int b = 0; b < 4; b++) begin
        fr_dat[b] = vecs[t].dat[8*b +: 8];
        fr_err[b] = vecs[t].err[b];
      end
      run_frame(t, vecs[t].n, vecs[t].und, vecs[t].ext, vecs[t].eerr, 1'b0, -1, bc);
      check($sformatf("vec%0d busy length", t), 32'(bc), 32'(vecs[t].exp_busy));
    end

    // Asynchronous reset in the middle of DATA.
    fr_dat[0] = 8'hAA; fr_dat[1] = 8'hBB; fr_dat[2] = 8'hCC;
    fr_err[0] = 1'b0;  fr_err[1] = 1'b0;  fr_err[2] = 1'b0;
    run_frame(100, 3, 3, 0, 0, 1'b0, P + 3, bc);
    #2;
    tx_rst_n = 1'b0;
    #1;
    check("async reset mid-frame", 32'({txd, tx_en, tx_er, busy, data_ready}), 32'h0);
    tick(v);
    check("reset held mid-frame", 32'(v), 32'h0);
    prev_en  = 1'b0;
    tx_rst_n = 1'b1;
    idle_cycles("after mid-frame reset", 3);
    run_frame(101, 3, 3, 0, 0, 1'b0, -1, bc);

    // data_valid held across two frames: gap of IPG+1 cycles with tx_en low.
    run_frame(200, 3, 3, 0, 0, 1'b1, -1, bc);
    run_frame(201, 3, 3, 0, 0, 1'b0, -1, bc);
    check("back-to-back tx_en gap", 32'(last_gap), 32'(IPG + 1));

    for (int r = 0; r < 24; r++) begin
      n   = $urandom_range(1, 8);
      und = ($urandom_range(0, 3) == 0) ? $urandom_range(0, n - 1) : n;
      ext = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(1, 5);
      for (int b = 0; b < n; b++) begin
        fr_dat[b] = 8'($urandom);
        fr_err[b] = ($urandom_range(0, 5) == 0);
      end
      run_frame(300 + r, n, und, ext, -1, 1'($urandom), -1, bc);
    end

    idle_cycles("final", 2);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
